// File: rtl/pdm_pkg.sv
// -----------------------------------------------------------------------------
// pdm_pkg
// Shared types, default parameters and sizing helpers for the PDM word
// decimator and its output FIFO.
//
// Contents:
//   - default parameter values (word length, decimation, sample width, ...)
//   - acc_width()   : accumulator width, $clog2(WORD_LENGTH*DECIMATION_WORDS + 1)
//   - scale_shift() : left shift applied to the centred sum (negative = right)
//   - pcm_sample_t  : signed PCM sample of the default width
//   - PDM_SAT_MAX / PDM_SAT_MIN : saturation limits of pcm_sample_t
// -----------------------------------------------------------------------------
package pdm_pkg;

  localparam int PDM_WORD_LENGTH      = 16;
  localparam int PDM_DECIMATION_WORDS = 4;
  localparam int PDM_SAMPLE_WIDTH     = 16;
  localparam int PDM_FIFO_DEPTH       = 8;
  localparam int PDM_DC_SHIFT         = 8;

  // Bits needed to hold a full decimation sum (0 .. WORD_LENGTH*DECIMATION_WORDS).
  function automatic int acc_width(input int word_length, input int decimation_words);
    return $clog2(word_length * decimation_words + 1);
  endfunction

  // Shift that maps the centred sum (range +/- WORD_LENGTH*DECIMATION_WORDS)
  // onto the full signed sample range. Negative means shift right.
  function automatic int scale_shift(input int sample_width, input int word_length,
                                     input int decimation_words);
    return sample_width - 1 - $clog2(word_length * decimation_words);
  endfunction

  localparam int PDM_ACC_W       = acc_width(PDM_WORD_LENGTH, PDM_DECIMATION_WORDS);
  localparam int PDM_SCALE_SHIFT = scale_shift(PDM_SAMPLE_WIDTH, PDM_WORD_LENGTH,
                                               PDM_DECIMATION_WORDS);

  typedef logic signed [PDM_SAMPLE_WIDTH-1:0] pcm_sample_t;

  localparam pcm_sample_t PDM_SAT_MAX = {1'b0, {(PDM_SAMPLE_WIDTH-1){1'b1}}};
  localparam pcm_sample_t PDM_SAT_MIN = {1'b1, {(PDM_SAMPLE_WIDTH-1){1'b0}}};

endpackage

// File: rtl/pdm_sample_fifo.sv
// -----------------------------------------------------------------------------
// pdm_sample_fifo
// Synchronous show-ahead FIFO with occupancy output and a sticky overflow flag.
// The head entry is presented on rd_data_o whenever rd_valid_o is high; a pop
// happens on a cycle with rd_valid_o && rd_ready_i. Writes to a full FIFO are
// dropped unless a pop happens in the same cycle.
//
// Ports:
//   clock_i          in   system clock
//   reset_n_i        in   asynchronous active-low reset
//   clear_i          in   synchronous clear of pointers, level and overflow
//   wr_en_i          in   write strobe
//   wr_data_i        in   write data
//   rd_ready_i       in   sink accepts head entry (ignored when empty)
//   rd_data_o        out  head entry (0 when empty)
//   rd_valid_o       out  FIFO non-empty
//   level_o          out  occupancy, 0..DEPTH
//   overflow_clear_i in   clears overflow_o (a new overflow wins)
//   overflow_o       out  sticky: a write was dropped
// -----------------------------------------------------------------------------
module pdm_sample_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8
) (
  input  logic                       clock_i,
  input  logic                       reset_n_i,
  input  logic                       clear_i,
  input  logic                       wr_en_i,
  input  logic [DATA_W-1:0]          wr_data_i,
  input  logic                       rd_ready_i,
  output logic [DATA_W-1:0]          rd_data_o,
  output logic                       rd_valid_o,
  output logic [$clog2(DEPTH):0]     level_o,
  input  logic                       overflow_clear_i,
  output logic                       overflow_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [LVL_W-1:0]  r_level;
  logic              r_overflow;

  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_drop;

  assign w_empty = (r_level == '0);
  assign w_full  = (r_level == LVL_W'(DEPTH));
  assign w_pop   = !w_empty && rd_ready_i;
  // A pop frees the slot the same cycle, so a write into a full FIFO is kept.
  assign w_push  = wr_en_i && (!w_full || w_pop);
  assign w_drop  = wr_en_i && w_full && !w_pop;

  always_ff @(posedge clock_i) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= wr_data_i;
    end
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
    end else if (clear_i) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (overflow_clear_i) begin
        r_overflow <= 1'b0;
      end
    end
  end

  // Storage is not reset, so the head is masked while empty.
  assign rd_data_o  = w_empty ? '0 : r_mem[r_rd_ptr];
  assign rd_valid_o = !w_empty;
  assign level_o    = r_level;
  assign overflow_o = r_overflow;

endmodule

// File: rtl/pdm_word_decimator.sv
// -----------------------------------------------------------------------------
// pdm_word_decimator
// Counts the ones in each packed PDM word, sums DECIMATION_WORDS counts,
// centres and scales the sum into a signed saturated PCM sample and buffers
// the samples in a show-ahead FIFO with a ready/valid output.
//
// Optional feature (macro PDM_DECIM_DC_BLOCK_EN): a DC-tracking stage after
// saturation subtracts a slowly moving estimate of the sample mean. It adds
// one cycle of latency (3 -> 4 cycles from last strobe to sample_valid_o).
//
// Ports:
//   clock_i          in   system clock
//   reset_n_i        in   asynchronous active-low reset
//   enable_i         in   low = synchronous clear of all datapath state
//   word_valid_i     in   one-cycle strobe per PDM word
//   word_i           in   PDM word, MSB oldest
//   sample_o         out  signed PCM sample at FIFO head
//   sample_valid_o   out  FIFO non-empty
//   sample_ready_i   in   sink accepts sample_o
//   fifo_level_o     out  FIFO occupancy
//   overflow_o       out  sticky: a sample was dropped
//   overflow_clear_i in   clears overflow_o
// -----------------------------------------------------------------------------
module pdm_word_decimator
  import pdm_pkg::*;
#(
  parameter int WORD_LENGTH      = PDM_WORD_LENGTH,
  parameter int DECIMATION_WORDS = PDM_DECIMATION_WORDS,
  parameter int SAMPLE_WIDTH     = PDM_SAMPLE_WIDTH,
  parameter int FIFO_DEPTH       = PDM_FIFO_DEPTH,
  parameter int DC_SHIFT         = PDM_DC_SHIFT
) (
  input  logic                          clock_i,
  input  logic                          reset_n_i,
  input  logic                          enable_i,
  input  logic                          word_valid_i,
  input  logic [WORD_LENGTH-1:0]        word_i,
  output logic [SAMPLE_WIDTH-1:0]       sample_o,
  output logic                          sample_valid_o,
  input  logic                          sample_ready_i,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
  output logic                          overflow_o,
  input  logic                          overflow_clear_i
);

  localparam int TOTAL_BITS = WORD_LENGTH * DECIMATION_WORDS;
  localparam int ACC_W      = acc_width(WORD_LENGTH, DECIMATION_WORDS);
  localparam int PC_W       = $clog2(WORD_LENGTH + 1);
  localparam int CNT_W      = (DECIMATION_WORDS > 1) ? $clog2(DECIMATION_WORDS) : 1;
  localparam int SHIFT      = scale_shift(SAMPLE_WIDTH, WORD_LENGTH, DECIMATION_WORDS);
  // Wide enough for the centred sum (sign + doubling) plus any left shift.
  localparam int RAW_W      = ACC_W + 2 + ((SHIFT > 0) ? SHIFT : 0);

  localparam logic signed [RAW_W-1:0] SAT_MAX_W =
    $signed({{(RAW_W-SAMPLE_WIDTH+1){1'b0}}, {(SAMPLE_WIDTH-1){1'b1}}});
  localparam logic signed [RAW_W-1:0] SAT_MIN_W =
    $signed({{(RAW_W-SAMPLE_WIDTH+1){1'b1}}, {(SAMPLE_WIDTH-1){1'b0}}});
  localparam logic [SAMPLE_WIDTH-1:0] SAT_MAX = {1'b0, {(SAMPLE_WIDTH-1){1'b1}}};
  localparam logic [SAMPLE_WIDTH-1:0] SAT_MIN = {1'b1, {(SAMPLE_WIDTH-1){1'b0}}};

  // ---------------------------------------------------------------------------
  // Stage 1: popcount
  // ---------------------------------------------------------------------------
  logic [PC_W-1:0] w_popcount;
  logic [PC_W-1:0] r_pc;
  logic            r_pc_valid;

  always_comb begin
    w_popcount = '0;
    for (int i = 0; i < WORD_LENGTH; i++) begin
      w_popcount = w_popcount + PC_W'(word_i[i]);
    end
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_pc       <= '0;
      r_pc_valid <= 1'b0;
    end else if (!enable_i) begin
      r_pc       <= '0;
      r_pc_valid <= 1'b0;
    end else begin
      r_pc_valid <= word_valid_i;
      if (word_valid_i) begin
        r_pc <= w_popcount;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: accumulate, centre, scale, saturate
  // ---------------------------------------------------------------------------
  logic [ACC_W-1:0]        r_acc;
  logic [CNT_W-1:0]        r_word_cnt;
  logic [SAMPLE_WIDTH-1:0] r_smp;
  logic                    r_smp_valid;

  logic                    w_last;
  logic [ACC_W-1:0]        w_sum;
  logic signed [RAW_W-1:0] w_raw;
  logic signed [RAW_W-1:0] w_scaled;
  logic [SAMPLE_WIDTH-1:0] w_sat;

  assign w_last = (r_word_cnt == CNT_W'(DECIMATION_WORDS - 1));
  assign w_sum  = r_acc + ACC_W'(r_pc);
  // raw = 2*sum - WORD_LENGTH*DECIMATION_WORDS: zero for a 50% ones density.
  assign w_raw  = $signed(({{(RAW_W-ACC_W){1'b0}}, w_sum} << 1) - RAW_W'(TOTAL_BITS));

  generate
    if (SHIFT >= 0) begin : g_scale_left
      assign w_scaled = w_raw <<< SHIFT;
    end else begin : g_scale_right
      assign w_scaled = w_raw >>> (-SHIFT);
    end
  endgenerate

  assign w_sat = (w_scaled > SAT_MAX_W) ? SAT_MAX :
                 (w_scaled < SAT_MIN_W) ? SAT_MIN :
                 w_scaled[SAMPLE_WIDTH-1:0];

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_acc       <= '0;
      r_word_cnt  <= '0;
      r_smp       <= '0;
      r_smp_valid <= 1'b0;
    end else if (!enable_i) begin
      r_acc       <= '0;
      r_word_cnt  <= '0;
      r_smp       <= '0;
      r_smp_valid <= 1'b0;
    end else begin
      r_smp_valid <= 1'b0;
      if (r_pc_valid) begin
        if (w_last) begin
          r_acc       <= '0;
          r_word_cnt  <= '0;
          r_smp       <= w_sat;
          r_smp_valid <= 1'b1;
        end else begin
          r_acc      <= w_sum;
          r_word_cnt <= r_word_cnt + CNT_W'(1);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Optional DC blocker, then FIFO write
  // ---------------------------------------------------------------------------
  logic                    w_fifo_wr;
  logic [SAMPLE_WIDTH-1:0] w_fifo_data;

`ifdef PDM_DECIM_DC_BLOCK_EN
  localparam int DC_W = SAMPLE_WIDTH + DC_SHIFT;

  // r_dc holds the running mean with DC_SHIFT fractional bits; its top
  // SAMPLE_WIDTH bits are the mean in sample units.
  logic signed [DC_W-1:0]         r_dc;
  logic [SAMPLE_WIDTH-1:0]        r_dc_out;
  logic                           r_dc_valid;
  logic signed [SAMPLE_WIDTH-1:0] w_dc_top;
  logic signed [SAMPLE_WIDTH:0]   w_dc_diff;
  logic signed [DC_W:0]           w_dc_step;
  logic [SAMPLE_WIDTH-1:0]        w_dc_sat;

  assign w_dc_top  = $signed(r_dc[DC_W-1:DC_SHIFT]);
  assign w_dc_diff = $signed({r_smp[SAMPLE_WIDTH-1], r_smp}) -
                     $signed({w_dc_top[SAMPLE_WIDTH-1], w_dc_top});
  // (sample - mean) / 2^DC_SHIFT, with the sample brought into r_dc's scale.
  assign w_dc_step = ($signed({r_smp[SAMPLE_WIDTH-1], r_smp, {DC_SHIFT{1'b0}}}) -
                      $signed({r_dc[DC_W-1], r_dc})) >>> DC_SHIFT;
  assign w_dc_sat  =
    (w_dc_diff > $signed({2'b00, {(SAMPLE_WIDTH-1){1'b1}}})) ? SAT_MAX :
    (w_dc_diff < $signed({2'b11, {(SAMPLE_WIDTH-1){1'b0}}})) ? SAT_MIN :
    w_dc_diff[SAMPLE_WIDTH-1:0];

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_dc       <= '0;
      r_dc_out   <= '0;
      r_dc_valid <= 1'b0;
    end else if (!enable_i) begin
      r_dc       <= '0;
      r_dc_out   <= '0;
      r_dc_valid <= 1'b0;
    end else begin
      r_dc_valid <= r_smp_valid;
      if (r_smp_valid) begin
        r_dc_out <= w_dc_sat;
        r_dc     <= r_dc + w_dc_step[DC_W-1:0];
      end
    end
  end

  assign w_fifo_wr   = r_dc_valid;
  assign w_fifo_data = r_dc_out;
`else
  // Without the DC stage DC_SHIFT has no hardware; the block below is empty
  // for any legal value and only keeps the parameter part of the interface.
  generate
    if (DC_SHIFT < 0) begin : g_dc_shift_unused
    end
  endgenerate

  assign w_fifo_wr   = r_smp_valid;
  assign w_fifo_data = r_smp;
`endif

  // ---------------------------------------------------------------------------
  // Stage 3: output FIFO
  // ---------------------------------------------------------------------------
  pdm_sample_fifo #(
    .DATA_W (SAMPLE_WIDTH),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clock_i          (clock_i),
    .reset_n_i        (reset_n_i),
    .clear_i          (!enable_i),
    .wr_en_i          (w_fifo_wr),
    .wr_data_i        (w_fifo_data),
    .rd_ready_i       (sample_ready_i),
    .rd_data_o        (sample_o),
    .rd_valid_o       (sample_valid_o),
    .level_o          (fifo_level_o),
    .overflow_clear_i (overflow_clear_i),
    .overflow_o       (overflow_o)
  );

endmodule

// File: tb/tb_pdm_word_decimator.sv
// -----------------------------------------------------------------------------
// tb_pdm_word_decimator
// Self-checking bench for pdm_word_decimator with default parameters
// (16-bit words, 4 words per sample, 16-bit samples, 8-entry FIFO).
// -----------------------------------------------------------------------------
module tb_pdm_word_decimator;

  logic        clk;
  logic        reset_n;
  logic        enable;
  logic        word_valid;
  logic [15:0] word;
  logic [15:0] sample;
  logic        sample_valid;
  logic        sample_ready;
  logic [3:0]  level;
  logic        overflow;
  logic        overflow_clear;

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_q[$];

  pdm_word_decimator dut (
    .clock_i          (clk),
    .reset_n_i        (reset_n),
    .enable_i         (enable),
    .word_valid_i     (word_valid),
    .word_i           (word),
    .sample_o         (sample),
    .sample_valid_o   (sample_valid),
    .sample_ready_i   (sample_ready),
    .fifo_level_o     (level),
    .overflow_o       (overflow),
    .overflow_clear_i (overflow_clear)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] word;
    int          gap;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %h expected %h", name, act, exp);
    end
  endtask

  // Reference: sum of ones over 4 words -> centred, scaled by 2^9, clamped.
  function automatic logic [15:0] ref_sample(input int sum);
    longint v;
    v = longint'(2 * sum - 64) * 512;
    if (v > 32767) v = 32767;
    if (v < -32768) v = -32768;
    return 16'(v);
  endfunction

  // Called at posedge+1; returns at posedge+1 after the last strobe.
  task automatic drive_words(input logic [15:0] w, input int n, input int gap);
    for (int k = 0; k < n; k++) begin
      word_valid = 1'b1;
      word       = w;
      @(posedge clk); #1;
      word_valid = 1'b0;
      if (k < n - 1) begin
        repeat (gap) begin @(posedge clk); #1; end
      end
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pop_one();
    sample_ready = 1'b1;
    @(posedge clk); #1;
    sample_ready = 1'b0;
  endtask

  initial begin
    logic [15:0] w;
    int          pc_sum;
    int          n_words;

    reset_n        = 1'b0;
    enable         = 1'b1;
    word_valid     = 1'b0;
    word           = '0;
    sample_ready   = 1'b0;
    overflow_clear = 1'b0;

    // Reset state
    #3;
    check("reset_valid", 32'(sample_valid), 32'd0);
    check("reset_sample", 32'(sample), 32'd0);
    check("reset_level", 32'(level), 32'd0);
    check("reset_overflow", 32'(overflow), 32'd0);
    #19 reset_n = 1'b1;
    @(posedge clk); #1;

    // Table-driven: 4 identical words, latency and value
    vecs[0] = '{16'hFFFF, 0, 16'h7FFF};
    vecs[1] = '{16'h0000, 0, 16'h8000};
    vecs[2] = '{16'hAAAA, 0, 16'h0000};
    vecs[3] = '{16'h0FFF, 2, 16'h4000};
    vecs[4] = '{16'h0FFF, 0, 16'h4000};
    vecs[5] = '{16'h00FF, 1, 16'h0000};
    vecs[6] = '{16'h000F, 0, 16'hC000};
    vecs[7] = '{16'h7FFF, 3, 16'h7000};
    vecs[8] = '{16'h8000, 0, 16'h9000};
    vecs[9] = '{16'h3FFF, 0, 16'h6000};

    for (int i = 0; i < 10; i++) begin
      drive_words(vecs[i].word, 4, vecs[i].gap);
      check($sformatf("vec%0d_lat_c1", i), 32'(sample_valid), 32'd0);
      wait_cycles(1);
      check($sformatf("vec%0d_lat_c2", i), 32'(sample_valid), 32'd0);
      wait_cycles(1);
      check($sformatf("vec%0d_lat_c3", i), 32'(sample_valid), 32'd1);
      check($sformatf("vec%0d_sample", i), 32'(sample), 32'(vecs[i].exp));
      check($sformatf("vec%0d_level", i), 32'(level), 32'd1);
      $display("vec %0d word %h gap %0d sample %h", i, vecs[i].word, vecs[i].gap, sample);
      pop_one();
      check($sformatf("vec%0d_drained", i), 32'(level), 32'd0);
    end

    // Overflow: 9 samples with no sink, 9th dropped
    for (int k = 0; k < 9; k++) begin
      w = 16'((32'd1 << (4 + k)) - 1);
      if (k < 8) exp_q.push_back(ref_sample(4 * (4 + k)));
      drive_words(w, 4, 0);
      wait_cycles(3);
    end
    check("ovf_level", 32'(level), 32'd8);
    check("ovf_flag", 32'(overflow), 32'd1);
    sample_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      check($sformatf("ovf_drain%0d_valid", k), 32'(sample_valid), 32'd1);
      check($sformatf("ovf_drain%0d_sample", k), 32'(sample), 32'(exp_q[0]));
      $display("drain %0d sample %h", k, sample);
      void'(exp_q.pop_front());
      @(posedge clk); #1;
    end
    sample_ready = 1'b0;
    check("ovf_drain_empty", 32'(sample_valid), 32'd0);
    check("ovf_sticky", 32'(overflow), 32'd1);
    overflow_clear = 1'b1;
    @(posedge clk); #1;
    overflow_clear = 1'b0;
    check("ovf_cleared", 32'(overflow), 32'd0);
    $display("overflow sequence done level %0d", level);

    // Asynchronous reset mid-group
    drive_words(16'hFFFF, 4, 0);
    wait_cycles(3);
    check("rst_pre_valid", 32'(sample_valid), 32'd1);
    drive_words(16'h0000, 2, 0);
    #2 reset_n = 1'b0;
    #1;
    check("rst_async_valid", 32'(sample_valid), 32'd0);
    check("rst_async_sample", 32'(sample), 32'd0);
    check("rst_async_level", 32'(level), 32'd0);
    #2 reset_n = 1'b1;
    @(posedge clk); #1;
    drive_words(16'hFFFF, 4, 0);
    wait_cycles(5);
    check("rst_after_level", 32'(level), 32'd1);
    check("rst_after_sample", 32'(sample), 32'h7FFF);
    $display("reset sequence sample %h level %0d", sample, level);
    pop_one();

    // enable_i low discards a partial group
    drive_words(16'hFFFF, 2, 0);
    enable = 1'b0;
    @(posedge clk); #1;
    enable = 1'b1;
    drive_words(16'h0000, 4, 0);
    wait_cycles(5);
    check("en_level", 32'(level), 32'd1);
    check("en_sample", 32'(sample), 32'h8000);
    $display("enable sequence sample %h level %0d", sample, level);
    pop_one();

    // Randomized traffic against the reference model
    pc_sum  = 0;
    n_words = 0;
    for (int c = 0; c < 600 || n_words != 0; c++) begin
      word_valid   = ($urandom_range(0, 2) != 0);
      word         = 16'($urandom);
      sample_ready = ($urandom_range(0, 3) != 0);
      if (word_valid) begin
        pc_sum += $countones(word);
        n_words++;
        if (n_words == 4) begin
          exp_q.push_back(ref_sample(pc_sum));
          pc_sum  = 0;
          n_words = 0;
        end
      end
      #1;
      if (sample_valid && sample_ready) begin
        if (exp_q.size() == 0) begin
          check("rand_unexpected", 32'(sample), 32'hFFFF_FFFF);
        end else begin
          check("rand_sample", 32'(sample), 32'(exp_q[0]));
          $display("rand pop sample %h", sample);
          void'(exp_q.pop_front());
        end
      end
      @(posedge clk); #1;
    end
    word_valid   = 1'b0;
    sample_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (sample_valid) begin
        if (exp_q.size() == 0) begin
          check("rand_unexpected", 32'(sample), 32'hFFFF_FFFF);
        end else begin
          check("rand_tail_sample", 32'(sample), 32'(exp_q[0]));
          $display("rand pop sample %h", sample);
          void'(exp_q.pop_front());
        end
      end
      @(posedge clk); #1;
    end
    sample_ready = 1'b0;
    check("rand_all_popped", 32'(exp_q.size()), 32'd0);
    check("rand_level", 32'(level), 32'd0);
    check("rand_overflow", 32'(overflow), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
